// File: rtl/uart_rx_buffer.sv
// ---------------------------------------------------------------------------
// uart_rx_buffer
//   Receive-side buffer behind the UART core. Every UART interrupt delivers
//   one byte and its error flags. The block acknowledges each one and queues
//   it in a show-ahead FIFO that the host drains through a valid/enable port.
//   Bytes that arrive while the FIFO is full are discarded. Those losses are
//   recorded in a sticky overflow flag and a saturating drop counter.
//
// Ports
//   i_clock            system clock, rising edge
//   i_reset            synchronous active-high reset
//   i_uart_data        received byte, valid while i_uart_interrupt=1
//   i_uart_errors      error flags for that byte
//   i_uart_interrupt   level request, held until acknowledged
//   o_uart_acknowledge acknowledge back to the UART
//   i_read_enable      host pop request (ignored while empty)
//   o_read_data        head-of-FIFO byte (0 when empty)
//   o_read_errors      head-of-FIFO error flags (0 when empty)
//   o_read_valid       FIFO non-empty
//   o_count            current occupancy, 0..2**DEPTH_LOG2
//   o_overflow         sticky: at least one byte dropped
//   i_clear_overflow   clears o_overflow and o_drop_count
//   o_drop_count       number of dropped bytes, saturating at 255
// ---------------------------------------------------------------------------
module uart_rx_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ERROR_WIDTH = 3,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [DATA_WIDTH-1:0]   i_uart_data,
  input  logic [ERROR_WIDTH-1:0]  i_uart_errors,
  input  logic                    i_uart_interrupt,
  output logic                    o_uart_acknowledge,
  input  logic                    i_read_enable,
  output logic [DATA_WIDTH-1:0]   o_read_data,
  output logic [ERROR_WIDTH-1:0]  o_read_errors,
  output logic                    o_read_valid,
  output logic [DEPTH_LOG2:0]     o_count,
  output logic                    o_overflow,
  input  logic                    i_clear_overflow,
  output logic [7:0]              o_drop_count
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = DATA_WIDTH + ERROR_WIDTH;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  typedef enum logic {
    S_IDLE         = 1'b0,
    S_WAIT_RELEASE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [ENTRY_W-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic [7:0]            r_drop_count;

  logic                  w_capture;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_write;
  logic                  w_drop;
  logic [ENTRY_W-1:0]    w_head;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic: one capture per interrupt pulse, then wait for release
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:         if (i_uart_interrupt)  w_state_next = S_WAIT_RELEASE;
      S_WAIT_RELEASE: if (!i_uart_interrupt) w_state_next = S_IDLE;
      default:        w_state_next = S_IDLE;
    endcase
  end

  // Output decode. The acknowledge comes straight from the state flop, so it
  // rises at the capture edge and falls at the first edge that sees release.
  always_comb begin
    o_uart_acknowledge = (r_state == S_WAIT_RELEASE);
    w_capture          = (r_state == S_IDLE) && i_uart_interrupt;
  end

  // A pop in the capture cycle frees a slot, so a full FIFO still accepts.
  assign w_pop   = i_read_enable && (r_count != '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_write = w_capture && (!w_full || w_pop);
  assign w_drop  = w_capture && w_full && !w_pop;

  // FIFO control
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage carries data only, so it has no reset
  always_ff @(posedge i_clock) begin
    if (w_write) r_mem[r_wr_ptr] <= {i_uart_errors, i_uart_data};
  end

  // Overflow tracking: a drop in the same cycle as a clear leaves one count
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      r_drop_count <= i_clear_overflow ? 8'd1 : sat_inc8(r_drop_count);
    end else if (i_clear_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign o_read_valid  = (r_count != '0);
  assign o_read_data   = o_read_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign o_read_errors = o_read_valid ? w_head[ENTRY_W-1:DATA_WIDTH] : '0;
  assign o_count       = r_count;
  assign o_overflow    = r_overflow;
  assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] uart_data;
  logic [2:0] uart_errors;
  logic       uart_int;
  logic       uart_ack;
  logic       read_en;
  logic [7:0] read_data;
  logic [2:0] read_errors;
  logic       read_valid;
  logic [4:0] count;
  logic       overflow;
  logic       clear_ovf;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected FIFO contents {errors, data}, plus overflow model
  logic [10:0] sb[$];
  logic        m_ovf;
  logic [7:0]  m_drop;

  typedef struct {
    bit         is_pop;
    logic [7:0] data;
    logic [2:0] err;
    int         exp_count;
    bit         exp_valid;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  uart_rx_buffer #(.DATA_WIDTH(8), .ERROR_WIDTH(3), .DEPTH_LOG2(4)) dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_uart_data        (uart_data),
    .i_uart_errors      (uart_errors),
    .i_uart_interrupt   (uart_int),
    .o_uart_acknowledge (uart_ack),
    .i_read_enable      (read_en),
    .o_read_data        (read_data),
    .o_read_errors      (read_errors),
    .o_read_valid       (read_valid),
    .o_count            (count),
    .o_overflow         (overflow),
    .i_clear_overflow   (clear_ovf),
    .o_drop_count       (drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(sb.size()));
    check({tag, "_valid"}, 32'(read_valid), 32'(sb.size() != 0));
    check({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
    check({tag, "_drop"},  32'(drop_count), 32'(m_drop));
  endtask

  // One complete interrupt handshake. Pop/clear are driven only in the
  // capture cycle; the interrupt stays high for 'hold' edges after the ack.
  task automatic send(input logic [7:0] d, input logic [2:0] e, input bit pop,
                      input bit clr, input int hold, input bit full_chk);
    bit do_pop;
    bit full;
    uart_data   = d;
    uart_errors = e;
    uart_int    = 1'b1;
    read_en     = pop;
    clear_ovf   = clr;
    do_pop = pop && (sb.size() != 0);
    full   = (sb.size() == 16);
    if (do_pop) begin
      check("head_data_before_pop", 32'(read_data), 32'(sb[0][7:0]));
      check("head_err_before_pop", 32'(read_errors), 32'(sb[0][10:8]));
    end
    tick();
    read_en   = 1'b0;
    clear_ovf = 1'b0;
    if (do_pop) void'(sb.pop_front());
    if (!full || do_pop) begin
      sb.push_back({e, d});
      if (clr) begin m_ovf = 1'b0; m_drop = 8'd0; end
    end else begin
      m_ovf  = 1'b1;
      m_drop = clr ? 8'd1 : ((m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1);
    end
    check("ack_rise", 32'(uart_ack), 32'd1);
    if (full_chk) check_status("capture");
    for (int i = 0; i < hold; i++) begin
      tick();
      check("ack_hold", 32'(uart_ack), 32'd1);
    end
    uart_int = 1'b0;
    tick();
    check("ack_fall", 32'(uart_ack), 32'd0);
    if (full_chk) check("count_after_release", 32'(count), 32'(sb.size()));
  endtask

  task automatic pop();
    check("pop_valid", 32'(read_valid), 32'd1);
    check("pop_data", 32'(read_data), 32'(sb[0][7:0]));
    check("pop_err", 32'(read_errors), 32'(sb[0][10:8]));
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    void'(sb.pop_front());
    check("pop_count", 32'(count), 32'(sb.size()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    m_ovf  = 1'b0;
    m_drop = 8'd0;
  endtask

  initial begin
    rst = 1'b0; uart_data = '0; uart_errors = '0; uart_int = 1'b0;
    read_en = 1'b0; clear_ovf = 1'b0;
    m_ovf = 1'b0; m_drop = 8'd0;

    vecs[0] = '{is_pop: 1'b0, data: 8'hA5, err: 3'b100, exp_count: 1, exp_valid: 1'b1};
    vecs[1] = '{is_pop: 1'b0, data: 8'h3C, err: 3'b001, exp_count: 2, exp_valid: 1'b1};
    vecs[2] = '{is_pop: 1'b1, data: 8'hA5, err: 3'b100, exp_count: 1, exp_valid: 1'b1};
    vecs[3] = '{is_pop: 1'b1, data: 8'h3C, err: 3'b001, exp_count: 0, exp_valid: 1'b0};

    // Reset state
    tick();
    do_reset();
    check("rst_ack", 32'(uart_ack), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(read_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_rdata", 32'(read_data), 32'd0);

    // Single byte, interrupt held 3 cycles past the ack
    send(8'hFF, 3'b000, 1'b0, 1'b0, 3, 1'b1);
    check("single_data", 32'(read_data), 32'hFF);
    check("single_count", 32'(count), 32'd1);
    pop();

    // Table-driven ordering test
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].is_pop) begin
        check("tbl_data", 32'(read_data), 32'(vecs[i].data));
        check("tbl_err", 32'(read_errors), 32'(vecs[i].err));
        pop();
      end else begin
        send(vecs[i].data, vecs[i].err, 1'b0, 1'b0, 0, 1'b1);
      end
      check("tbl_count", 32'(count), 32'(vecs[i].exp_count));
      check("tbl_valid", 32'(read_valid), 32'(vecs[i].exp_valid));
    end

    // Fill, drop one, then accept one with a same-cycle pop
    for (int i = 0; i < 16; i++) send(8'(i), 3'(i), 1'b0, 1'b0, 0, 1'b1);
    send(8'h10, 3'b010, 1'b0, 1'b0, 0, 1'b1);
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_cnt1", 32'(drop_count), 32'd1);
    check("drop_count16", 32'(count), 32'd16);
    send(8'h11, 3'b011, 1'b1, 1'b0, 0, 1'b1);
    check("full_pop_count", 32'(count), 32'd16);
    check("full_pop_drop", 32'(drop_count), 32'd1);

    // Saturate the drop counter
    for (int i = 0; i < 300; i++) send(8'(i), 3'b111, 1'b0, 1'b0, 0, 1'b0);
    check_status("sat");
    check("sat_255", 32'(drop_count), 32'd255);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    m_ovf = 1'b0; m_drop = 8'd0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_drop", 32'(drop_count), 32'd0);

    // Drop coinciding with clear
    send(8'h55, 3'b000, 1'b0, 1'b1, 0, 1'b1);
    check("drop_clr_drop", 32'(drop_count), 32'd1);
    check("drop_clr_ovf", 32'(overflow), 32'd1);

    // Drain and confirm order 0x01..0x0F, 0x11
    for (int i = 0; i < 16; i++) begin
      check("drain_expected", 32'(read_data), (i < 15) ? 32'(i + 1) : 32'h11);
      pop();
    end
    check("drain_valid", 32'(read_valid), 32'd0);
    pop_empty_check: begin
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      check("underflow_count", 32'(count), 32'd0);
    end

    // Reset during WAIT_RELEASE with 5 queued entries
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 3'b000, 1'b0, 1'b0, 0, 1'b1);
    uart_data = 8'h24; uart_errors = 3'b000; uart_int = 1'b1;
    tick();
    check("wr_ack", 32'(uart_ack), 32'd1);
    check("wr_count5", 32'(count), 32'd5);
    uart_int = 1'b0;
    do_reset();
    check("midrst_ack", 32'(uart_ack), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_valid", 32'(read_valid), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);

    // Streaming with concurrent pops across pointer wrap
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'b1, 1'b0, 0, 1'b1);
      checks++;
      if (count > 5'd16) begin
        errors++;
        $display("FAIL stream_count_bound: got %0d, required <= 16", count);
      end
    end
    check("stream_drop", 32'(drop_count), 32'd0);
    while (sb.size() != 0) pop();
    check("stream_empty", 32'(read_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Receive-side stage directly downstream of the UART core.
- Captures each received byte plus its 3-bit error flags when the UART raises its host interrupt, and returns the acknowledge.
- Queues entries in a FIFO so the host can drain them at its own pace through a valid/enable read port.
- Tracks overflow (bytes discarded because the FIFO was full) so host software can detect lost data.

Parameters:
- DATA_WIDTH, 8: received byte width; matches the UART data port.
- ERROR_WIDTH, 3: error-flag width; matches the UART error port.
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 entries (default 16).

Ports:
- Clock  input  1  single system clock; all logic on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- UartData  input  DATA_WIDTH  received byte from the UART; valid while UartInterrupt=1.
- UartErrors  input  ERROR_WIDTH  error flags for that byte; valid while UartInterrupt=1.
- UartInterrupt  input  1  level; UART holds it high until it sees UartAcknowledge.
- UartAcknowledge  output  1  registered acknowledge to the UART.
- ReadEnable  input  1  host pop request; ignored when ReadValid=0.
- ReadData  output  DATA_WIDTH  head-of-FIFO byte (show-ahead).
- ReadErrors  output  ERROR_WIDTH  head-of-FIFO error flags.
- ReadValid  output  1  FIFO non-empty.
- Count  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
- Overflow  output  1  sticky: at least one byte dropped.
- ClearOverflow  input  1  clears Overflow and DropCount.
- DropCount  output  8  number of dropped bytes; saturates at 255.

Behaviour:
- Reset (sampled at a rising edge) values:
  - State=IDLE.
  - UartAcknowledge=0, Count=0, ReadValid=0.
  - Overflow=0, DropCount=0.
  - Read/write pointers=0.
  - ReadData/ReadErrors are don't-care while ReadValid=0; the implementation drives them to 0.
- Reset mid-handshake aborts it: UartAcknowledge drops in the next cycle and FIFO contents are lost. If UartInterrupt is still high after reset, it is captured as a new byte.
- Capture FSM, 2 states:
  - IDLE: UartAcknowledge=0. When UartInterrupt=1 is sampled at edge N:
    - Accepted (Count < depth, or ReadEnable&&ReadValid in the same cycle): {UartErrors,UartData} written at edge N.
    - Dropped (full and no pop that cycle): entry discarded; Overflow set at edge N; DropCount+1, saturating.
    - Either case: UartAcknowledge=1 from edge N; go to WAIT_RELEASE.
  - WAIT_RELEASE: UartAcknowledge held 1. At the first edge with UartInterrupt=0, UartAcknowledge=0 and return to IDLE. No further capture in this state, so one interrupt pulse yields exactly one entry.
- Capture latency: entry visible on ReadValid/ReadData one cycle after the sampling edge, i.e. outputs valid after edge N.
- FIFO:
  - Show-ahead; pop takes effect at the edge where ReadEnable&&ReadValid.
  - Pointers are DEPTH_LOG2 bits, wrap modulo depth. Count is tracked explicitly.
  - Simultaneous write and pop: Count unchanged, holds even at full or at Count=1. When empty, no pop occurs, so a same-cycle write simply lands.
  - ReadEnable with ReadValid=0: no effect, no underflow.
- Overflow/DropCount:
  - ClearOverflow=1 zeroes both at that edge.
  - A drop in the same cycle as ClearOverflow wins: Overflow=1, DropCount=1.
- Registered outputs: UartAcknowledge, Count, Overflow, DropCount. ReadValid=(Count!=0).
- Target size: about 150-250 lines of RTL.

Test Plan:
- Reset, then UartInterrupt=1 with UartData=0xFF, UartErrors=3'b000. Deassert the interrupt 3 cycles after the ack rises -> exactly one entry; ReadValid=1, ReadData=0xFF, Count=1; ack high for the full handshake, low the cycle after the interrupt drops.
- Capture 0xA5/3'b100, then 0x3C/3'b001, then pop twice -> read in order 0xA5/100 then 0x3C/001; Count 2->1->0; ReadValid=0 after the second pop.
- Fill 16 entries 0x00..0x0F, then send 0x10 with no pop -> Count stays 16, Overflow=1, DropCount=1, ack still given. Then send 0x11 while ReadEnable=1 in the capture cycle -> Count stays 16, 0x11 stored, DropCount stays 1.
- Hold the FIFO full and send 300 further bytes -> DropCount saturates at 255. Then assert ClearOverflow=1 -> Overflow=0, DropCount=0.
- Assert Reset while in WAIT_RELEASE with 5 entries queued -> next cycle UartAcknowledge=0, Count=0, ReadValid=0, Overflow=0.
- Write/pop wrap-around: 40 bytes streamed with concurrent pops -> data order preserved across pointer wrap; Count never exceeds 16; no spurious drops.
